// File: rtl/execute_cc.sv
// Y86-64 execute stage: 64-bit ALU, branch/cmov condition
// evaluation and the architectural ZF/SF/OF register.
module execute_cc #(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             cc_en,
  output logic [WIDTH-1:0] valE,
  output logic             Cnd,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic             exe_error
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic             zf_q, sf_q, of_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ok;
  logic             cond;
  logic             cond_ok;
  logic             cc_we;

  // OPq arithmetic with signed-overflow detection
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ok  = 1'b1;
    case (ifun)
      4'd0: begin
        alu_res = valB + valA;
        alu_ovf = (valA[MSB] == valB[MSB]) &&
                  (alu_res[MSB] != valA[MSB]);
      end
      4'd1: begin
        alu_res = valB - valA;
        alu_ovf = (valB[MSB] != valA[MSB]) &&
                  (alu_res[MSB] != valB[MSB]);
      end
      4'd2:    alu_res = valB & valA;
      4'd3:    alu_res = valB ^ valA;
      default: alu_ok  = 1'b0;
    endcase
  end

  // Condition from the flags as they stand before this edge
  always_comb begin
    cond    = 1'b0;
    cond_ok = 1'b1;
    case (ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (sf_q ^ of_q) | zf_q;
      4'd2:    cond = sf_q ^ of_q;
      4'd3:    cond = zf_q;
      4'd4:    cond = !zf_q;
      4'd5:    cond = !(sf_q ^ of_q);
      4'd6:    cond = !(sf_q ^ of_q) && !zf_q;
      default: cond_ok = 1'b0;
    endcase
  end

  // Result select per instruction, error and CC write enable
  always_comb begin
    valE      = '0;
    Cnd       = 1'b0;
    exe_error = 1'b0;
    cc_we     = 1'b0;
    case (icode)
      I_CMOV: begin
        if (cond_ok) begin
          valE = valA;
          Cnd  = cond;
        end else begin
          exe_error = 1'b1;
        end
      end
      I_IRMOV: valE = valC;
      I_RMMOV,
      I_MRMOV: valE = valB + valC;
      I_OPQ: begin
        if (alu_ok) begin
          valE  = alu_res;
          cc_we = cc_en;
        end else begin
          exe_error = 1'b1;
        end
      end
      I_JXX: begin
        if (cond_ok) Cnd = cond;
        else exe_error = 1'b1;
      end
      I_CALL,
      I_PUSH: valE = valB - STEP;
      I_RET,
      I_POP: valE = valB + STEP;
      default: valE = '0;
    endcase
  end

  // Condition-code register; reset beats an OPq update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_we) begin
      zf_q <= (alu_res == '0);
      sf_q <= alu_res[MSB];
      of_q <= alu_ovf;
    end
  end

  assign ZF = zf_q;
  assign SF = sf_q;
  assign OF = of_q;

endmodule

// File: tb/tb_execute_cc.sv
// Bench for execute_cc: directed scenarios plus random
// traffic against a behavioural Y86-64 execute model.
module tb_execute_cc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic        cc_en;
  logic [63:0] valE;
  logic        Cnd, ZF, SF, OF, exe_error;

  int total = 0;
  int bad   = 0;

  bit m_zf, m_sf, m_of;

  always #5 clk = ~clk;

  execute_cc #(.WIDTH(64), .STACK_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC),
    .cc_en(cc_en),
    .valE(valE), .Cnd(Cnd),
    .ZF(ZF), .SF(SF), .OF(OF),
    .exe_error(exe_error)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: arithmetic on wide signed values
  task automatic model(input  logic [3:0]  ic,
                       input  logic [3:0]  fn,
                       input  logic [63:0] a, b, c,
                       output logic [63:0] e,
                       output bit cnd, err, upd,
                       output bit nz, ns, no);
    logic signed [65:0] wide;
    logic signed [65:0] lo, hi;
    bit lt;
    lo = -(66'sd1 <<< 63);
    hi = (66'sd1 <<< 63) - 66'sd1;
    e = 0; cnd = 0; err = 0; upd = 0;
    nz = 0; ns = 0; no = 0;
    lt = m_sf != m_of;
    if (ic == 4'h2 || ic == 4'h7) begin
      if (fn > 6) err = 1;
      else begin
        case (fn)
          0: cnd = 1;
          1: cnd = lt || m_zf;
          2: cnd = lt;
          3: cnd = m_zf;
          4: cnd = !m_zf;
          5: cnd = !lt;
          default: cnd = !lt && !m_zf;
        endcase
        if (ic == 4'h2) e = a;
      end
    end else if (ic == 4'h6) begin
      if (fn > 3) err = 1;
      else begin
        upd = 1;
        wide = 0;
        if (fn == 0) begin
          wide = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
          e = b + a;
        end else if (fn == 1) begin
          wide = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
          e = b - a;
        end else if (fn == 2) e = b & a;
        else e = b ^ a;
        nz = (e == 0);
        ns = e[63];
        no = (fn < 2) && (wide < lo || wide > hi);
      end
    end else if (ic == 4'h3) e = c;
    else if (ic == 4'h4 || ic == 4'h5) e = b + c;
    else if (ic == 4'h8 || ic == 4'hA) e = b - 64'd8;
    else if (ic == 4'h9 || ic == 4'hB) e = b + 64'd8;
  endtask

  // One clock: drive, check combinational outputs, then flags
  task automatic cyc(input logic [3:0]  ic, fn,
                     input logic [63:0] a, b, c,
                     input logic en, rn);
    logic [63:0] e;
    bit cnd, err, upd, nz, ns, no;
    icode = ic; ifun = fn;
    valA = a; valB = b; valC = c;
    cc_en = en; rst_n = rn;
    model(ic, fn, a, b, c, e, cnd, err, upd, nz, ns, no);
    #3;
    chk("valE", valE, e);
    chk("Cnd", 64'(Cnd), 64'(cnd));
    chk("exe_error", 64'(exe_error), 64'(err));
    @(posedge clk);
    if (!rn) begin
      m_zf = 1; m_sf = 0; m_of = 0;
    end else if (upd && en) begin
      m_zf = nz; m_sf = ns; m_of = no;
    end
    #1;
    chk("ZF", 64'(ZF), 64'(m_zf));
    chk("SF", 64'(SF), 64'(m_sf));
    chk("OF", 64'(OF), 64'(m_of));
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [63:0] a, b;
    icode = 0; ifun = 0; valA = 0; valB = 0; valC = 0;
    cc_en = 0; rst_n = 0;
    @(posedge clk);
    #1;
    m_zf = 1; m_sf = 0; m_of = 0;
    chk("rst_ZF", 64'(ZF), 64'd1);
    chk("rst_SF", 64'(SF), 64'd0);
    chk("rst_OF", 64'(OF), 64'd0);

    cyc(4'h7, 4'd3, 0, 0, 0, 0, 1);
    cyc(4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1);
    chk("addovf_OF", 64'(OF), 64'd1);
    cyc(4'h7, 4'd2, 0, 0, 0, 0, 1);
    cyc(4'h6, 4'd1, 64'h374, 64'h374, 0, 1, 1);
    chk("sub0_ZF", 64'(ZF), 64'd1);
    cyc(4'h7, 4'd3, 0, 0, 0, 0, 1);
    cyc(4'h7, 4'd4, 0, 0, 0, 0, 1);
    cyc(4'h5, 4'd0, 0, 64'h100, 64'h1FF, 1, 1);
    cyc(4'h8, 4'd0, 0, 64'h37C, 0, 1, 1);
    cyc(4'hB, 4'd0, 0, 64'h374, 0, 1, 1);
    cyc(4'hB, 4'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1);
    cyc(4'h6, 4'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1, 1);
    cyc(4'h6, 4'd1, 64'h55, 64'h55, 0, 0, 1);
    cyc(4'h6, 4'd5, 64'h1, 64'h2, 0, 1, 1);
    cyc(4'h2, 4'd9, 64'h1, 64'h2, 0, 1, 1);
    cyc(4'h6, 4'd3, 64'hF0, 64'h0F, 0, 1, 0);
    chk("rstwin_ZF", 64'(ZF), 64'd1);

    for (int i = 0; i < 400; i++) begin
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? a : pick();
      cyc(4'($urandom_range(0, 15)),
          4'($urandom_range(0, 9)),
          a, b, pick(),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 30) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_cc.md
Name: execute_cc

Overview:
- Execute stage of the Y86-64 sequential processor. Sits directly upstream of the memory stage and produces the valE that memory uses as its address or stack pointer.
- Computes valE with a 64-bit ALU and evaluates the branch/cmov condition Cnd.
- Owns the architectural condition-code register (ZF, SF, OF). The CC register updates on the clock edge that retires an OPq.

Parameters:
- WIDTH, 64, datapath width of valA, valB, valC and valE.
- STACK_STEP, 8, stack-pointer adjustment in bytes for call/ret/pushq/popq.

Ports:
- clk  in  1  system clock; the CC register updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- icode  in  4  instruction code from decode.
- ifun  in  4  function code: ALU op for OPq, condition for jXX/cmovXX.
- valA  in  WIDTH  operand A from the register file.
- valB  in  WIDTH  operand B from the register file.
- valC  in  WIDTH  immediate or displacement.
- cc_en  in  1  CC write permission; driven 0 when an earlier-stage exception is pending.
- valE  out  WIDTH  ALU result, to memory and writeback.
- Cnd  out  1  condition outcome for jXX/cmovXX.
- ZF  out  1  registered zero flag.
- SF  out  1  registered sign flag.
- OF  out  1  registered overflow flag.
- exe_error  out  1  asserted for an invalid ifun on OPq, jXX or cmovXX.

Behaviour:
- Reset: one clock, synchronous, active-low. When rst_n=0 at a rising edge: ZF=1, SF=0, OF=0. Reset has priority over any concurrent OPq update.
- valE, Cnd and exe_error are combinational, zero latency. They do not depend on reset apart from their dependence on ZF/SF/OF.
- valE by icode:
  - 2 (cmovXX): valA.
  - 3 (irmovq): valC.
  - 4, 5 (rmmovq, mrmovq): valB+valC.
  - 6 (OPq), by ifun: 0 = valB+valA, 1 = valB−valA, 2 = valB&valA, 3 = valB^valA.
  - 8, A (call, pushq): valB−STACK_STEP.
  - 9, B (ret, popq): valB+STACK_STEP.
  - All other icodes: 0.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Cnd for icode 2 and 7, evaluated from the *current registered* CC (before any update this cycle), by ifun:
  - 0: 1.
  - 1 (le): (SF^OF)|ZF.
  - 2 (l): SF^OF.
  - 3 (e): ZF.
  - 4 (ne): !ZF.
  - 5 (ge): !(SF^OF).
  - 6 (g): !(SF^OF)&!ZF.
  - For all other icodes, Cnd=0.
- Error cases:
  - ifun>3 on OPq, or ifun>6 on jXX/cmovXX: exe_error=1, Cnd=0, valE=0, and no CC update.
  - Otherwise exe_error=0.
- CC update at a rising edge requires rst_n=1, icode=6, cc_en=1 and exe_error=0. Then:
  - ZF ← (result==0).
  - SF ← result[WIDTH−1].
  - OF:
    - add: (a[msb]==b[msb]) & (r[msb]!=a[msb]).
    - sub (valB−valA): (valB[msb]!=valA[msb]) & (r[msb]!=valB[msb]).
    - and/xor: 0.
- When the update conditions are not met, the CC holds its value.
- Back-to-back: an OPq followed by a jXX in the next cycle sees the flags produced by that OPq.
- Inputs are sampled only at the edge; changes between edges affect only the combinational outputs.

Test Plan:
- Reset: hold rst_n=0 for one edge → ZF=1, SF=0, OF=0. Then icode=7, ifun=3 → Cnd=1.
- Add overflow: icode=6, ifun=0, valA=1, valB=64'h7FFFFFFFFFFFFFFF, cc_en=1 → valE=64'h8000000000000000. After the edge, ZF=0, SF=1, OF=1. Next cycle icode=7, ifun=2 (l) → Cnd=0.
- Equal subtract then branch: ifun=1, valA=valB=64'h374 → valE=0. After the edge ZF=1. Next cycle jXX ifun=3 → Cnd=1; ifun=4 → Cnd=0.
- Memory/stack addressing, each with CC unchanged:
  - icode=5, valB=64'h100, valC=64'h1FF → valE=64'h2FF.
  - icode=8, valB=64'h37C → valE=64'h374.
  - icode=B, valB=64'h374 → valE=64'h37C.
  - icode=B, valB=64'hFFFFFFFFFFFFFFFC → valE=64'h4 (wrap).
- Inhibit and error cases, each with flags unchanged after the edge:
  - OPq sub with result 0 and cc_en=0.
  - OPq ifun=5 → exe_error=1, valE=0.
  - cmovXX ifun=9 → exe_error=1, Cnd=0.
- Reset mid-operation: OPq xor with a nonzero result and rst_n=0 at the same edge → ZF=1, SF=0, OF=0 (reset wins).
